vs_sci_sdi_responder: RTL and testbench
=======================================

Name: vs_sci_sdi_responder

Overview:
Synthesizable model of the decoder-chip end of the MP3 serial link: the SCI/SDI responder that the MP3 controller drives over XCS/XDCS/SCK/SI. It oversamples the serial lines in the CLK domain and decodes 32-bit SCI register commands into a 16x16 register file. It buffers SDI stream bytes in a FIFO, drives DREQ from FIFO free space and busy timers, and hands bytes to a downstream consumer with valid/ready. Used as an on-FPGA loopback target and as the bench-side partner of the controller.

Parameters:
FIFO_DEPTH, 64, SDI byte FIFO depth (power of 2, >= 2*DREQ_FREE).
DREQ_FREE, 32, minimum free FIFO bytes for DREQ high.
SCI_BUSY_CYCLES, 16, CLK cycles DREQ is held low after any SCI write.
RESET_CYCLES, 1000, CLK cycles DREQ is held low after soft or hardware reset.

Ports:
CLK  in  1  system clock; SCK high and low phases each >= 3 CLK cycles.
rst  in  1  synchronous active-high reset.
i_XCS  in  1  SCI chip select, active low.
i_XDCS  in  1  SDI data select, active low.
i_SCK  in  1  serial clock from the controller.
i_SI  in  1  serial data in, MSB first, sampled on SCK rise.
i_XRST  in  1  chip hardware reset, active low.
o_SO  out  1  serial data out for SCI reads.
o_DREQ  out  1  ready for SCI/SDI traffic.
o_reg_wr  out  1  one-cycle pulse on a completed SCI write.
o_reg_addr  out  4  address of the write.
o_reg_data  out  16  data of the write.
o_data_byte  out  8  FIFO head byte.
o_data_valid  out  1  FIFO not empty.
i_data_ready  in  1  consumer accepts the byte when valid & ready.
o_overflow  out  1  sticky: an SDI byte was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 or synchronized i_XRST=0): all outputs 0 except o_DREQ, which stays 0 until the busy timer expires. Busy timer loads RESET_CYCLES. Registers default: reg0 (MODE)=0x0800, others 0x0000. FIFO empty, o_overflow=0.
- i_XCS, i_XDCS, i_SCK, i_SI, i_XRST pass through 2-FF synchronizers. SCK rise and fall are detected from the synchronized samples.
- XCS falling clears the SCI bit counter. SCI FSM: SCI_IDLE -> SCI_OP (8 bits) -> SCI_ADDR (8) -> SCI_DATA (16) -> SCI_DONE, which waits for XCS high.
- Opcode 0x02 (write): on the 32nd SCK rise, if addr<16, write reg[addr[3:0]], pulse o_reg_wr on the next cycle, and load the busy timer with SCI_BUSY_CYCLES. addr>=16: no write and no pulse.
- Any other opcode: remaining bits ignored until XCS high.
- XCS rising before bit 32: abort, no write, return to SCI_IDLE.
- Write of MODE with bit2 (SM_RESET) set: flush FIFO, load busy timer with RESET_CYCLES, and clear bit2 in the stored MODE. Other registers are unchanged.
- SDI: with XDCS=0 and XCS=1, bits shift MSB first and each 8th bit pushes a byte. On a full FIFO the byte is dropped and o_overflow is set. XDCS rising drops a partial byte.
- XCS=0 and XDCS=0 together: SCI wins and SDI bits are ignored.
- o_DREQ = (busy timer == 0) & (free >= DREQ_FREE), registered with one cycle latency.
- Output side: o_data_byte/o_data_valid reflect the FIFO head and hold until accepted. Simultaneous push and pop on a full FIFO is allowed: the pop frees the slot, so no overflow.
- SO: 0 when XCS=1 or when the optional feature is disabled.

Optional Feature:
VS_SCI_READ_EN
- Defined: opcode 0x03 is a read. After the 16th bit (address) the FSM loads reg[addr[3:0]] (0x0000 if addr>=16). o_SO presents bit15 immediately and shifts to the next bit on each of the following SCK falls (16 bits). Reads do not start the busy timer.
- Undefined: 0x03 is handled like any unknown opcode and o_SO stays tied to 0.

Decomposition:
- Package vs_pkg holds:
  - opcode constants OP_WRITE=8'h02 and OP_READ=8'h03;
  - register addresses ADDR_MODE=4'h0 and ADDR_VOL=4'hB;
  - MODE_DEFAULT=16'h0800 and the SM_RESET bit index 2;
  - the SCI state enum.
- One sub-module, vs_sdi_fifo: synchronous byte FIFO with push, pop, flush, free count and full/empty.

Test Plan:
- Reset, then wait RESET_CYCLES -> o_DREQ rises; MODE reads 0x0800.
- SCI 32'h020B0000 -> o_reg_wr pulse with addr=0xB, data=0x0000; DREQ low for 16 cycles.
- SCI 32'h02000804 -> FIFO flushed; DREQ low for 1000 cycles; stored MODE=0x0800.
- SDI word 16'hFEFE with ready=1 -> bytes 0xFE then 0xFE on the valid/ready handshake.
- 65 bytes with ready=0 -> DREQ falls after byte 33; byte 65 dropped; o_overflow=1.
- XCS raised after 20 SCI bits -> no o_reg_wr. With VS_SCI_READ_EN, 0x030B after VOL=0x1234 -> SO yields 0x1234.

Source files
------------

// File: rtl/vs_sci_sdi_responder_pkg.sv
// vs_sci_sdi_responder_pkg: shared opcodes, register addresses and SCI state enum
package vs_pkg;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [3:0] ADDR_MODE = 4'h0;
  localparam logic [3:0] ADDR_VOL = 4'hB;
  localparam logic [15:0] MODE_DEFAULT = 16'h0800;
  localparam int SM_RESET = 2;
  typedef enum logic [2:0] {SCI_IDLE, SCI_OP, SCI_ADDR, SCI_DATA, SCI_DONE} sci_state_e;
endpackage

// File: rtl/vs_sci_sdi_responder_if.sv
// vs_sci_sdi_responder_if: serial link plus register-write and byte-stream side of the responder
interface vs_sci_sdi_responder_if;
  logic i_XCS, i_XDCS, i_SCK, i_SI, i_XRST, i_data_ready;
  logic o_SO, o_DREQ, o_reg_wr, o_data_valid, o_overflow;
  logic [3:0] o_reg_addr;
  logic [15:0] o_reg_data;
  logic [7:0] o_data_byte;
  modport master (
    output i_XCS, i_XDCS, i_SCK, i_SI, i_XRST, i_data_ready,
    input o_SO, o_DREQ, o_reg_wr, o_reg_addr, o_reg_data, o_data_byte, o_data_valid, o_overflow
  );
  modport slave (
    input i_XCS, i_XDCS, i_SCK, i_SI, i_XRST, i_data_ready,
    output o_SO, o_DREQ, o_reg_wr, o_reg_addr, o_reg_data, o_data_byte, o_data_valid, o_overflow
  );
endinterface

// File: rtl/vs_sci_sdi_responder_fifo.sv
// vs_sdi_fifo: synchronous byte FIFO with flush, free count and combinational head
module vs_sdi_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     free
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wp, rp, cnt;
  logic do_push, do_pop;
  assign cnt = wp - rp;
  assign empty = wp == rp;
  assign full = cnt == (AW + 1)'(DEPTH);
  assign free = (AW + 1)'(DEPTH) - cnt;
  assign dout = mem[rp[AW-1:0]];
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = push && (!full || pop);
  assign do_pop = pop && !empty;
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk)
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/vs_sci_sdi_responder.sv
// vs_sci_sdi_responder: SCI register / SDI byte-stream responder of the MP3 decoder link.
// Define VS_SCI_READ_EN to enable SCI reads (opcode 0x03) on SO.
module vs_sci_sdi_responder
  import vs_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int DREQ_FREE = 32,
  parameter int SCI_BUSY_CYCLES = 16,
  parameter int RESET_CYCLES = 1000
) (
  input logic CLK,
  input logic rst,
  vs_sci_sdi_responder_if.slave bus
);
`ifdef VS_SCI_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TMAX = RESET_CYCLES > SCI_BUSY_CYCLES ? RESET_CYCLES : SCI_BUSY_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  logic [4:0] s1, s2;
  logic [1:0] s3;
  logic xrst_s, xcs_s, xdcs_s, sck_s, si_s, srst, sck_rise, sck_fall, xcs_fall;
  sci_state_e state;
  logic [4:0] cnt;
  logic [30:0] sr;
  logic [15:0] so_sr, wd, rd_val, reg_data;
  logic [15:0] regs [16];
  logic [TW-1:0] busy;
  logic [7:0] sd_sr, op7, head;
  logic [2:0] sd_cnt;
  logic [3:0] wa, reg_addr;
  logic dreq, reg_wr, ovf, op_ok, sci_wr, soft_rst, push, pop, empty, full;
  logic [AW:0] free;
  // order: {XRST, XCS, XDCS, SCK, SI}; idle levels on reset
  always_ff @(posedge CLK)
    if (rst) begin
      s1 <= 5'b11100;
      s2 <= 5'b11100;
      s3 <= 2'b10;
    end else begin
      s1 <= {bus.i_XRST, bus.i_XCS, bus.i_XDCS, bus.i_SCK, bus.i_SI};
      s2 <= s1;
      s3 <= {s2[3], s2[1]};
    end
  assign {xrst_s, xcs_s, xdcs_s, sck_s, si_s} = s2;
  assign srst = rst || !xrst_s;
  assign sck_rise = sck_s && !s3[0];
  assign sck_fall = !sck_s && s3[0];
  assign xcs_fall = !xcs_s && s3[1];
  assign op7 = {sr[6:0], si_s};
  assign op_ok = op7 == OP_WRITE || (READ_EN && op7 == OP_READ);
  assign wa = sr[18:15];
  assign wd = {sr[14:0], si_s};
  assign sci_wr = state == SCI_DATA && !xcs_s && sck_rise && cnt == 5'd31 &&
                  sr[30:23] == OP_WRITE && sr[22:19] == 4'h0;
  assign soft_rst = sci_wr && wa == ADDR_MODE && wd[SM_RESET];
  assign rd_val = sr[6:3] == 4'h0 ? regs[{sr[2:0], si_s}] : 16'h0;
  assign push = !xdcs_s && xcs_s && sck_rise && sd_cnt == 3'd7;
  assign pop = !empty && bus.i_data_ready;
  vs_sdi_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK), .rst(srst), .flush(soft_rst), .push(push), .pop(pop),
    .din({sd_sr[6:0], si_s}), .dout(head), .empty(empty), .full(full), .free(free)
  );
  always_ff @(posedge CLK)
    if (srst) begin
      state <= SCI_IDLE;
      cnt <= '0;
      sr <= '0;
      so_sr <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= i == 0 ? MODE_DEFAULT : 16'h0;
      busy <= TW'(RESET_CYCLES);
      dreq <= 1'b0;
      reg_wr <= 1'b0;
      reg_addr <= '0;
      reg_data <= '0;
      sd_sr <= '0;
      sd_cnt <= '0;
      ovf <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      busy <= busy == '0 ? '0 : busy - 1'b1;
      dreq <= busy == '0 && free >= (AW + 1)'(DREQ_FREE);
      ovf <= ovf || (push && full && !pop);
      if (xdcs_s) sd_cnt <= '0;
      else if (xcs_s && sck_rise) begin
        sd_sr <= {sd_sr[6:0], si_s};
        sd_cnt <= sd_cnt + 3'd1;
      end
      case (state)
        SCI_IDLE: if (xcs_fall) begin
          state <= SCI_OP;
          cnt <= '0;
        end
        SCI_DONE: if (xcs_s) begin
          state <= SCI_IDLE;
          so_sr <= '0;
        end
        default: if (xcs_s) begin
          state <= SCI_IDLE;
          so_sr <= '0;
        end else begin
          // the fall right after the load belongs to the address bit; hold bit15 through it
          if (sck_fall && state == SCI_DATA && cnt != 5'd16) so_sr <= so_sr << 1;
          if (sck_rise) begin
            sr <= {sr[29:0], si_s};
            cnt <= cnt + 5'd1;
            if (cnt == 5'd7) state <= op_ok ? SCI_ADDR : SCI_DONE;
            if (cnt == 5'd15) begin
              state <= SCI_DATA;
              if (READ_EN && sr[14:7] == OP_READ) so_sr <= rd_val;
            end
            if (cnt == 5'd31) state <= SCI_DONE;
          end
        end
      endcase
      if (sci_wr) begin
        reg_wr <= 1'b1;
        reg_addr <= wa;
        reg_data <= wd;
        regs[wa] <= soft_rst ? wd & ~(16'h1 << SM_RESET) : wd;
        busy <= TW'(soft_rst ? RESET_CYCLES : SCI_BUSY_CYCLES);
      end
    end
  assign bus.o_SO = READ_EN && !xcs_s && so_sr[15];
  assign bus.o_DREQ = dreq;
  assign bus.o_reg_wr = reg_wr;
  assign bus.o_reg_addr = reg_addr;
  assign bus.o_reg_data = reg_data;
  assign bus.o_data_valid = !empty;
  assign bus.o_data_byte = empty ? 8'h00 : head;
  assign bus.o_overflow = ovf;
endmodule

// File: tb/tb_vs_sci_sdi_responder.sv
// tb_vs_sci_sdi_responder: directed self-checking bench; read checks only when VS_SCI_READ_EN is defined
module tb_vs_sci_sdi_responder;
  logic CLK = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int low_cnt = 0;
  logic [3:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [7:0] got [$];
  vs_sci_sdi_responder_if bus ();
  vs_sci_sdi_responder dut (.CLK(CLK), .rst(rst), .bus(bus));
  always #5 CLK = ~CLK;
  always begin
    @(negedge CLK);
    #1;
    if (bus.o_reg_wr) begin
      wr_cnt++;
      wr_addr = bus.o_reg_addr;
      wr_data = bus.o_reg_data;
    end
    if (!bus.o_DREQ) low_cnt++;
    if (bus.o_data_valid && bus.i_data_ready) got.push_back(bus.o_data_byte);
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic sci(input logic [31:0] w, input int nb, output logic [15:0] rd);
    rd = '0;
    bus.i_XCS = 1'b0;
    cyc(4);
    for (int i = 0; i < nb; i++) begin
      bus.i_SI = w[31-i];
      cyc(4);
      if (i >= 16) rd = {rd[14:0], bus.o_SO};
      bus.i_SCK = 1'b1;
      cyc(4);
      bus.i_SCK = 1'b0;
    end
    cyc(4);
    bus.i_XCS = 1'b1;
    cyc(6);
  endtask
  task automatic sdi_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      bus.i_SI = b[7-i];
      cyc(4);
      bus.i_SCK = 1'b1;
      cyc(4);
      bus.i_SCK = 1'b0;
    end
    cyc(2);
  endtask
  initial begin
    logic [15:0] rd;
    int n, c0, l0;
    bus.i_XCS = 1'b1;
    bus.i_XDCS = 1'b1;
    bus.i_SCK = 1'b0;
    bus.i_SI = 1'b0;
    bus.i_XRST = 1'b1;
    bus.i_data_ready = 1'b0;
    cyc(5);
    chk("rst_dreq", bus.o_DREQ, 0);
    chk("rst_reg_wr", bus.o_reg_wr, 0);
    chk("rst_valid", bus.o_data_valid, 0);
    chk("rst_overflow", bus.o_overflow, 0);
    chk("rst_byte", bus.o_data_byte, 0);
    chk("rst_so", bus.o_SO, 0);
    rst = 1'b0;
    n = 0;
    while (!bus.o_DREQ && n < 1200) begin
      cyc(1);
      n++;
    end
    chk("dreq_after_reset", bus.o_DREQ, 1);
    chk("reset_busy_len_ok", n >= 1000 && n <= 1003, 1);
`ifdef VS_SCI_READ_EN
    sci(32'h03000000, 32, rd);
    chk("mode_default_read", rd, 16'h0800);
`endif
    // plain register write: one pulse, DREQ low for the SCI busy time
    l0 = low_cnt;
    sci(32'h020B0000, 32, rd);
    cyc(30);
    chk("vol_wr_count", wr_cnt, 1);
    chk("vol_wr_addr", wr_addr, 4'hB);
    chk("vol_wr_data", wr_data, 16'h0000);
    chk("vol_busy_len", low_cnt - l0, 16);
    chk("vol_dreq_back", bus.o_DREQ, 1);
    // one buffered byte, then soft reset must flush it
    bus.i_XDCS = 1'b0;
    cyc(4);
    sdi_byte(8'hA5);
    bus.i_XDCS = 1'b1;
    cyc(4);
    chk("sdi_a5_valid", bus.o_data_valid, 1);
    chk("sdi_a5_byte", bus.o_data_byte, 8'hA5);
    l0 = low_cnt;
    sci(32'h02000804, 32, rd);
    chk("softrst_wr_count", wr_cnt, 2);
    chk("softrst_wr_data", wr_data, 16'h0804);
    chk("softrst_flushed", bus.o_data_valid, 0);
    cyc(1100);
    chk("softrst_busy_len", low_cnt - l0, 1000);
    chk("softrst_dreq_back", bus.o_DREQ, 1);
`ifdef VS_SCI_READ_EN
    sci(32'h03000000, 32, rd);
    chk("mode_after_softrst", rd, 16'h0800);
`endif
    // streaming word with the consumer ready
    bus.i_data_ready = 1'b1;
    bus.i_XDCS = 1'b0;
    cyc(4);
    sdi_byte(8'hFE);
    sdi_byte(8'hFE);
    bus.i_XDCS = 1'b1;
    cyc(10);
    chk("fefe_count", got.size(), 2);
    chk("fefe_b0", got.size() > 0 ? got[0] : 8'hxx, 8'hFE);
    chk("fefe_b1", got.size() > 1 ? got[1] : 8'hxx, 8'hFE);
    chk("fefe_drained", bus.o_data_valid, 0);
    // fill past capacity with the consumer stalled
    bus.i_data_ready = 1'b0;
    cyc(2);
    got.delete();
    bus.i_XDCS = 1'b0;
    cyc(4);
    for (int i = 0; i < 65; i++) begin
      sdi_byte(8'(i));
      if (i == 31) chk("dreq_at_32", bus.o_DREQ, 1);
      if (i == 32) chk("dreq_at_33", bus.o_DREQ, 0);
      if (i == 63) chk("ovf_at_64", bus.o_overflow, 0);
    end
    bus.i_XDCS = 1'b1;
    cyc(4);
    chk("ovf_at_65", bus.o_overflow, 1);
    chk("full_head", bus.o_data_byte, 8'h00);
    bus.i_data_ready = 1'b1;
    cyc(100);
    chk("drain_count", got.size(), 64);
    chk("drain_first", got.size() > 0 ? got[0] : 8'hxx, 8'h00);
    chk("drain_last", got.size() > 63 ? got[63] : 8'hxx, 8'h3F);
    chk("ovf_sticky", bus.o_overflow, 1);
    chk("dreq_after_drain", bus.o_DREQ, 1);
    // aborted, out-of-range and unknown-opcode commands must not write
    c0 = wr_cnt;
    sci(32'h020B1234, 20, rd);
    chk("abort_no_wr", wr_cnt, c0);
    sci(32'h02100055, 32, rd);
    chk("addr16_no_wr", wr_cnt, c0);
    sci(32'h050B9999, 32, rd);
    chk("badop_no_wr", wr_cnt, c0);
    sci(32'h020B1234, 32, rd);
    chk("vol1234_wr_count", wr_cnt, c0 + 1);
    chk("vol1234_wr_addr", wr_addr, 4'hB);
    chk("vol1234_wr_data", wr_data, 16'h1234);
`ifdef VS_SCI_READ_EN
    sci(32'h030B0000, 32, rd);
    chk("vol_read", rd, 16'h1234);
    chk("wr_count_after_read", wr_cnt, c0 + 1);
`else
    sci(32'h030B0000, 32, rd);
    chk("so_tied_low", rd, 16'h0000);
`endif
    // hardware reset pin clears sticky state and drops DREQ
    bus.i_XRST = 1'b0;
    cyc(5);
    chk("xrst_dreq", bus.o_DREQ, 0);
    chk("xrst_overflow", bus.o_overflow, 0);
    bus.i_XRST = 1'b1;
    cyc(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
